hier_cfg_chain_tx: RTL and testbench
====================================

Name: hier_cfg_chain_tx

Overview:
Root-side transmitter for the hierarchy configuration chain. It accepts (node id, data) words from the root over a valid/ready handshake and serialises each word into a framed bit stream. The stream runs down the daisy chain of child instances. It then waits for the acknowledge returned by the addressed child and reports done or error to the root. The child-side receiver is the other end of this protocol.

Parameters:
ID_W, 3, node id width
DATA_W, 8, payload width
NUM_NODES, 5, number of addressable child nodes; valid ids are 0..NUM_NODES-1
TIMEOUT, 16, cycles allowed between the last frame bit and ack_in

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  root presents a word
in_ready  out  1  block can accept a word (state IDLE)
in_id  in  ID_W  target node id
in_data  in  DATA_W  configuration payload
ser_out  out  1  serial data to chain
ser_en  out  1  qualifies ser_out, one bit per cycle
ack_in  in  1  single-cycle acknowledge from addressed child
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on a successful transfer
err  out  1  one-cycle pulse on a bad id or a timeout

Behaviour:
- Reset, asynchronous and immediate, including mid-frame:
  - state=IDLE; ser_out=0, ser_en=0, busy=0, done=0, err=0; in_ready=1 after reset deasserts.
  - All counters are cleared.
  - A partial frame is abandoned; the receiver resynchronises on the next start bit.
- Frame format, FL = 2+ID_W+DATA_W bits (13 at defaults):
  - 1 start bit, value 1.
  - id, MSB first.
  - data, MSB first.
  - 1 even-parity bit computed over id and data, so the total count of ones across id, data and parity is even.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch id and data into a shift register.
    - If id < NUM_NODES, go to SHIFT.
    - Otherwise go to REJECT.
  - REJECT: err=1 for one cycle, no bits sent, then IDLE.
  - SHIFT:
    - ser_en=1 and ser_out=current bit for exactly FL consecutive cycles.
    - The first bit appears the cycle after acceptance.
    - Bit counter runs 0..FL-1; after the last bit, go to WAIT_ACK.
    - ack_in is ignored in SHIFT.
  - WAIT_ACK:
    - ser_en=0, ser_out=0.
    - Timeout counter starts at 0 on entry and increments each cycle.
    - If ack_in=1 in the same cycle the counter reaches TIMEOUT-1, ack wins.
    - ack_in=1 with count<TIMEOUT → DONE.
    - Count reaches TIMEOUT-1 without ack → ERR.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: err=1 for one cycle, then IDLE.
- Output rules:
  - done and err are never high together.
  - busy=!in_ready.
  - ser_out=0 whenever ser_en=0.
- Latency, good transfer: acceptance at cycle 0, bits on cycles 1..FL. An ack at WAIT_ACK cycle k gives done at cycle FL+k+2, and in_ready=1 on the following cycle.
- Back-to-back: a new word can be accepted in the first cycle of IDLE; there is no idle bubble requirement beyond this.
- in_valid is ignored while not IDLE. The input word is sampled only on handshake, so later changes have no effect.
- Counter widths are $clog2(FL) and $clog2(TIMEOUT)+1, with no wrap beyond their terminal values.

Decomposition:
- Package hier_cfg_pkg holds:
  - state enum {IDLE, SHIFT, WAIT_ACK, DONE, ERR, REJECT};
  - localparam function frame_len(ID_W, DATA_W);
  - START_BIT=1'b1;
  - parity helper function.
- Shared with the future receiver.
- One sub-module is natural: hier_cfg_frame_shifter, a parallel-load, MSB-first shift register with bit counter and last-bit flag.
- The FSM and timeout counter stay in the top module.

Test Plan:
- rst, then in_id=2, in_data=8'hA5 → ser_out on cycles 1..13 = 1,0,1,0,1,0,1,0,0,1,0,1,1 with ser_en=1; ack_in at WAIT_ACK cycle 3 → done pulse at cycle 18, err=0.
- in_id=7 (≥NUM_NODES=5), in_data=8'h00 → no ser_en, err=1 exactly one cycle after acceptance, in_ready=1 the cycle after that.
- in_id=0, in_data=8'hFF, no ack → 13 bits with parity bit 0; err pulse after 16 WAIT_ACK cycles; done never asserts.
- ack_in pulsed during SHIFT, then absent in WAIT_ACK → ack ignored, timeout err; then ack exactly at count 15 in a second transfer → done, not err.
- rst asserted at frame bit 6 → ser_en and ser_out go 0 asynchronously, busy=0; a following transfer (id=1, data=8'h3C) sends a complete correct frame.
- Two words held on in_valid back-to-back (id=4/8'h01, id=3/8'h80), each acked at WAIT_ACK cycle 0 → second accepted on first IDLE cycle; both frames and two done pulses are correct.

Source files
------------

// File: rtl/hier_cfg_pkg.sv
// Shared definitions for the hierarchy configuration chain (transmitter and receiver).
package hier_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      WAIT_ACK,
      DONE,
      ERR,
      REJECT
   } state_t;

   localparam logic START_BIT = 1'b1;

   // Frame: start bit + id + data + parity bit.
   function automatic int frame_len(input int id_w, input int data_w);
      return 2 + id_w + data_w;
   endfunction

   // Parity bit that makes the total number of ones (payload + parity) even.
   // Callers zero-extend the payload, which does not change its parity.
   function automatic logic even_parity(input logic [63:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/hier_cfg_chain_tx_shifter.sv
// Parallel-load, MSB-first frame shift register with bit counter and last-bit flag.
module hier_cfg_frame_shifter #(
   parameter int FL = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          shift_en,
   input  logic [FL-1:0] load_data,
   output logic          bit_out,
   output logic          last_bit
);

   localparam int CW = $clog2(FL);
   localparam logic [CW-1:0] LAST = CW'(FL - 1);

   logic [FL-1:0] sr_q;
   logic [CW-1:0] cnt_q;

   // Load a whole frame, then shift one bit per enabled cycle; the counter holds at the last bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (load) begin
         sr_q  <= load_data;
         cnt_q <= '0;
      end else if (shift_en) begin
         sr_q <= {sr_q[FL-2:0], 1'b0};
         if (cnt_q != LAST) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign bit_out  = sr_q[FL-1];
   assign last_bit = (cnt_q == LAST);

endmodule

// File: rtl/hier_cfg_chain_tx.sv
// Root-side transmitter: frames (id, data) words onto the daisy chain and waits for the child ack.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a word from the root
// SHIFT    | frame bits on ser_out, one per cycle
// WAIT_ACK | frame sent, counting cycles until ack_in or timeout
// DONE     | one-cycle done pulse
// ERR      | one-cycle err pulse after a timeout
// REJECT   | one-cycle err pulse for an id outside the node range
module hier_cfg_chain_tx
   import hier_cfg_pkg::*;
#(
   parameter int ID_W      = 3,
   parameter int DATA_W    = 8,
   parameter int NUM_NODES = 5,
   parameter int TIMEOUT   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ID_W-1:0]   in_id,
   input  logic [DATA_W-1:0] in_data,
   output logic              ser_out,
   output logic              ser_en,
   input  logic              ack_in,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int FL = frame_len(ID_W, DATA_W);
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [ID_W:0]   NODE_LIM = (ID_W + 1)'(NUM_NODES);

   state_t          state_q;
   state_t          state_d;
   logic [TW-1:0]   to_cnt_q;
   logic            accept;
   logic            id_ok;
   logic            sh_bit;
   logic            sh_last;
   logic [FL-1:0]   frame;

   assign accept = in_valid && (state_q == IDLE);
   assign id_ok  = ({1'b0, in_id} < NODE_LIM);
   assign frame  = {START_BIT, in_id, in_data, even_parity(64'({in_id, in_data}))};

   hier_cfg_frame_shifter #(
      .FL(FL)
   ) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .load      (accept && id_ok),
      .shift_en  (state_q == SHIFT),
      .load_data (frame),
      .bit_out   (sh_bit),
      .last_bit  (sh_last)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Ack timeout counter: zero outside WAIT_ACK, saturates at its terminal value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else if (state_q != WAIT_ACK) begin
         to_cnt_q <= '0;
      end else if (to_cnt_q != TO_LAST) begin
         to_cnt_q <= to_cnt_q + TW'(1);
      end
   end

   // Next-state and Moore outputs; an ack on the terminal count still counts as success.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      ser_en   = 1'b0;
      ser_out  = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (accept) begin
               state_d = id_ok ? SHIFT : REJECT;
            end
         end
         SHIFT: begin
            ser_en  = 1'b1;
            ser_out = sh_bit;
            if (sh_last) begin
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ack_in) begin
               state_d = DONE;
            end else if (to_cnt_q == TO_LAST) begin
               state_d = ERR;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         ERR, REJECT: begin
            err     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy = !in_ready;
   end

endmodule

// File: tb/tb_hier_cfg_chain_tx.sv
// Scoreboard bench for hier_cfg_chain_tx: stimulus pushes expected frames/outcomes, monitor checks them.
module tb_hier_cfg_chain_tx;

   localparam int ID_W      = 3;
   localparam int DATA_W    = 8;
   localparam int NUM_NODES = 5;
   localparam int TIMEOUT   = 16;
   localparam int FL        = 2 + ID_W + DATA_W;

   typedef struct {
      int bits;
      int nbits;
      int first;
      int end_cyc;
      bit is_done;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [ID_W-1:0]   in_id;
   logic [DATA_W-1:0] in_data;
   logic              ser_out;
   logic              ser_en;
   logic              ack_in;
   logic              busy;
   logic              done;
   logic              err;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   exp_t sb[$];

   hier_cfg_chain_tx #(
      .ID_W(ID_W), .DATA_W(DATA_W), .NUM_NODES(NUM_NODES), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_id(in_id), .in_data(in_data), .ser_out(ser_out), .ser_en(ser_en),
      .ack_in(ack_in), .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input bit ok, input longint got, input longint expv);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
      end
   endtask

   // Reference model: frame = 1, id MSB first, data MSB first, parity making the ones count even.
   function automatic exp_t model(input int id, input int data, input int ack_k, input int acc);
      exp_t e;
      int   ones;
      int   b;
      e.bits    = 0;
      e.nbits   = 0;
      e.first   = acc + 1;
      e.is_done = 1'b0;
      if (id >= NUM_NODES) begin
         e.end_cyc = acc + 1;
         return e;
      end
      ones    = 0;
      e.bits  = 1;
      e.nbits = 1;
      for (int i = ID_W - 1; i >= 0; i--) begin
         b = (id >> i) & 1;
         e.bits = (e.bits << 1) | b;
         ones += b;
         e.nbits++;
      end
      for (int i = DATA_W - 1; i >= 0; i--) begin
         b = (data >> i) & 1;
         e.bits = (e.bits << 1) | b;
         ones += b;
         e.nbits++;
      end
      e.bits = (e.bits << 1) | (ones % 2);
      e.nbits++;
      if (ack_k >= 0 && ack_k < TIMEOUT) begin
         e.is_done = 1'b1;
         e.end_cyc = acc + e.nbits + 2 + ack_k;
      end else begin
         e.end_cyc = acc + e.nbits + 1 + TIMEOUT;
      end
      return e;
   endfunction

   // Monitor: invariants every cycle, frame collection, scoreboard pop on done/err.
   int got_bits = 0;
   int got_n    = 0;
   int got_first = 0;
   int rdy_at   = -1;
   always @(negedge clk) begin
      exp_t e;
      chk("invariants", !(done && err) && (busy == !in_ready) && !(ser_out && !ser_en),
          {done, err, busy, in_ready, ser_en, ser_out}, 0);
      if (rst) begin
         got_bits = 0;
         got_n    = 0;
         rdy_at   = -1;
      end else begin
         if (ser_en) begin
            if (got_n == 0) got_first = cyc;
            got_bits = (got_bits << 1) | int'(ser_out);
            got_n++;
         end
         if (cyc == rdy_at) chk("ready_after_pulse", in_ready == 1'b1, in_ready, 1);
         if (done || err) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", 1'b0, {done, err}, 0);
            end else begin
               e = sb.pop_front();
               chk("outcome_done", done == e.is_done, done, e.is_done);
               chk("outcome_cycle", cyc == e.end_cyc, cyc, e.end_cyc);
               chk("frame_len", got_n == e.nbits, got_n, e.nbits);
               chk("frame_bits", got_bits == e.bits, got_bits, e.bits);
               if (e.nbits > 0) chk("first_bit_cycle", got_first == e.first, got_first, e.first);
            end
            got_bits = 0;
            got_n    = 0;
            rdy_at   = cyc + 1;
         end
      end
   end

   task automatic wait_empty();
      int guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         chk("completion_timeout", 1'b0, sb.size(), 0);
         sb.delete();
      end
   endtask

   // Issue one word; ack_k < 0 or >= TIMEOUT means no ack. Called and returns on a negedge.
   task automatic send(input int id, input int data, input int ack_k, input bit shift_ack,
                       input bit keep, output int acc);
      int guard = 0;
      in_valid = 1'b1;
      in_id    = id[ID_W-1:0];
      in_data  = data[DATA_W-1:0];
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      acc = cyc;
      if (!in_ready) begin
         chk("accept_timeout", 1'b0, 0, 1);
         in_valid = 1'b0;
         return;
      end
      sb.push_back(model(id, data, ack_k, acc));
      @(negedge clk);
      in_valid = keep;
      in_id    = ID_W'($urandom);
      in_data  = DATA_W'($urandom);
      if (id < NUM_NODES) begin
         if (shift_ack) begin
            while (cyc < acc + 5) @(negedge clk);
            ack_in = 1'b1;
            @(negedge clk);
            ack_in = 1'b0;
         end
         if (ack_k >= 0 && ack_k < TIMEOUT) begin
            while (cyc < acc + FL + 1 + ack_k) @(negedge clk);
            ack_in = 1'b1;
            @(negedge clk);
            ack_in = 1'b0;
         end
      end
      if (!keep) wait_empty();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int acc2;
      int k;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_id    = '0;
      in_data  = '0;
      ack_in   = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_outputs", {ser_en, ser_out, busy, done, err} == 5'b0,
          {ser_en, ser_out, busy, done, err}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", in_ready == 1'b1, in_ready, 1);

      send(2, 8'hA5, 3, 1'b0, 1'b0, acc);
      send(7, 8'h00, -1, 1'b0, 1'b0, acc);
      send(0, 8'hFF, -1, 1'b0, 1'b0, acc);
      send(1, 8'h5A, -1, 1'b1, 1'b0, acc);
      send(3, 8'hC3, TIMEOUT - 1, 1'b0, 1'b0, acc);

      // Reset in the middle of a frame: outputs drop immediately, next frame is clean.
      in_valid = 1'b1;
      in_id    = 3'd3;
      in_data  = 8'h96;
      while (!in_ready) @(negedge clk);
      acc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      while (cyc < acc + 6) @(negedge clk);
      chk("bit6_live", ser_en == 1'b1, ser_en, 1);
      #2 rst = 1'b1;
      #1;
      chk("midframe_rst", {ser_en, ser_out, busy} == 3'b0, {ser_en, ser_out, busy}, 0);
      @(negedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_midrst", in_ready == 1'b1, in_ready, 1);
      send(1, 8'h3C, 2, 1'b0, 1'b0, acc);

      // Back-to-back with in_valid held: second word accepted on the first IDLE cycle.
      send(4, 8'h01, 0, 1'b0, 1'b1, acc);
      send(3, 8'h80, 0, 1'b0, 1'b0, acc2);
      chk("back_to_back_gap", (acc2 - acc) == FL + 3, acc2 - acc, FL + 3);

      for (int n = 0; n < 30; n++) begin
         k = int'($urandom_range(0, TIMEOUT + 1));
         send(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), k,
              1'($urandom_range(0, 1)), 1'b0, acc);
      end
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
